// File: rtl/te_muldiv_pkg.sv
// Shared types and op-decode helpers for the iterative RV64M multiply/divide unit.
package te_muldiv_pkg;

    localparam int ITER64 = 64;
    localparam int ITER32 = 32;

    typedef enum logic [3:0] {
        OP_MUL    = 4'b0000,
        OP_MULH   = 4'b0001,
        OP_MULHSU = 4'b0010,
        OP_MULHU  = 4'b0011,
        OP_DIV    = 4'b0100,
        OP_DIVU   = 4'b0101,
        OP_REM    = 4'b0110,
        OP_REMU   = 4'b0111,
        OP_MULW   = 4'b1000,
        OP_DIVW   = 4'b1100,
        OP_DIVUW  = 4'b1101,
        OP_REMW   = 4'b1110,
        OP_REMUW  = 4'b1111
    } op_e;

    typedef enum logic [1:0] {IDLE, PREP, CALC, FIN} state_e;

    // 1001/1010/1011 are the only unassigned codes.
    function automatic logic is_legal(input logic [3:0] op);
        return !(op[3] && !op[2] && (op[1:0] != 2'b00));
    endfunction

    function automatic logic is_word(input logic [3:0] op);
        return op[3];
    endfunction

    function automatic logic is_mul(input logic [3:0] op);
        return is_legal(op) && !op[2];
    endfunction

    function automatic logic is_rem(input logic [3:0] op);
        return op[1];
    endfunction

    function automatic logic is_signed_a(input logic [3:0] op);
        return is_mul(op) ? (op[1:0] != 2'b11) : !op[0];
    endfunction

    function automatic logic is_signed_b(input logic [3:0] op);
        return is_mul(op) ? !op[1] : !op[0];
    endfunction

endpackage

// File: rtl/te_muldiv_step.sv
// One radix-2 iteration: shift-add multiply step or restoring-divide step.
module te_muldiv_step #(
    parameter int W = 64
) (
    input  logic         mul_mode,
    input  logic [W-1:0] hi,
    input  logic [W-1:0] lo,
    input  logic [W-1:0] operand,
    output logic [W-1:0] hi_next,
    output logic [W-1:0] lo_next
);

    logic [W:0] sum;
    logic [W:0] rem_sh;
    logic [W:0] diff;

    always_comb begin
        sum     = {1'b0, hi} + (lo[0] ? {1'b0, operand} : '0);
        rem_sh  = {hi, lo[W-1]};
        diff    = rem_sh - {1'b0, operand};
        hi_next = hi;
        lo_next = lo;
        if (mul_mode) begin
            // Carry out of the add shifts into the top of the product.
            hi_next = sum[W:1];
            lo_next = {sum[0], lo[W-1:1]};
        end else if (!diff[W]) begin
            hi_next = diff[W-1:0];
            lo_next = {lo[W-2:0], 1'b1};
        end else begin
            hi_next = rem_sh[W-1:0];
            lo_next = {lo[W-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/te_muldiv_unit.sv
// Iterative RV64M multiply/divide execute unit, one radix-2 step per clock.
//   state | meaning
//   IDLE  | waiting for start_i
//   PREP  | magnitudes, special-case detect, counter load
//   CALC  | one shift-add / restore-subtract step per cycle
//   FIN   | sign correction, result select, done_o
module te_muldiv_unit
    import te_muldiv_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic            flush_i,
    input  logic [3:0]      op_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic [4:0]      rd_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      rd_o
);

    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_e            state_q, state_d;
    logic [3:0]        op_q;
    logic [XLEN-1:0]   a_q, b_q;
    logic [4:0]        rd_q, rd_out_q;
    logic [XLEN-1:0]   hi_q, lo_q, bm_q;
    logic [6:0]        cnt_q;
    logic              neg_res_q, neg_rem_q, spec_q;
    logic [XLEN-1:0]   spec_res_q, result_q;

    logic              accept;
    logic              op_w, op_mul, op_div, sgn_a, sgn_b, neg_a, neg_b;
    logic              div_zero, div_ovf, special;
    logic [XLEN-1:0]   a_w, b_w, a_ext, b_ext, mag_a, mag_b, spec_res;
    logic [XLEN-1:0]   step_hi, step_lo;
    logic [2*XLEN-1:0] prod, prod_s;
    logic [31:0]       mulw_s;
    logic [XLEN-1:0]   quo_s, rem_s, div_sel, fin_res;

    always_comb begin
        op_w   = is_word(op_q);
        op_mul = is_mul(op_q);
        op_div = is_legal(op_q) && !op_mul;
        sgn_a  = is_signed_a(op_q);
        sgn_b  = is_signed_b(op_q);
        a_w    = {{(XLEN-32){a_q[31]}}, a_q[31:0]};
        b_w    = {{(XLEN-32){b_q[31]}}, b_q[31:0]};
        a_ext  = op_w ? (sgn_a ? a_w : {{(XLEN-32){1'b0}}, a_q[31:0]}) : a_q;
        b_ext  = op_w ? (sgn_b ? b_w : {{(XLEN-32){1'b0}}, b_q[31:0]}) : b_q;
        neg_a  = sgn_a & a_ext[XLEN-1];
        neg_b  = sgn_b & b_ext[XLEN-1];
        mag_a  = neg_a ? -a_ext : a_ext;
        mag_b  = neg_b ? -b_ext : b_ext;

        div_zero = op_div && (b_ext == '0);
        div_ovf  = op_div && sgn_a &&
                   (op_w ? ((a_q[31:0] == 32'h8000_0000) && (b_q[31:0] == 32'hFFFF_FFFF))
                         : ((a_q == MOST_NEG) && (b_q == '1)));
        special  = !is_legal(op_q) || div_zero || div_ovf;

        spec_res = '0;
        if (div_zero) begin
            spec_res = is_rem(op_q) ? (op_w ? a_w : a_q) : '1;
        end else if (div_ovf) begin
            spec_res = is_rem(op_q) ? '0 : (op_w ? a_w : a_q);
        end
    end

    te_muldiv_step #(.W(XLEN)) u_step (
        .mul_mode (op_mul),
        .hi       (hi_q),
        .lo       (lo_q),
        .operand  (bm_q),
        .hi_next  (step_hi),
        .lo_next  (step_lo)
    );

    // After 32 shift-add steps the W product sits one word up: its low half is lo_q[63:32].
    always_comb begin
        prod    = {hi_q, lo_q};
        prod_s  = neg_res_q ? -prod : prod;
        mulw_s  = neg_res_q ? -lo_q[63:32] : lo_q[63:32];
        quo_s   = neg_res_q ? -lo_q : lo_q;
        rem_s   = neg_rem_q ? -hi_q : hi_q;
        div_sel = is_rem(op_q) ? rem_s : quo_s;
        fin_res = '0;
        if (spec_q) begin
            fin_res = spec_res_q;
        end else if (op_mul) begin
            if (op_w)
                fin_res = {{(XLEN-32){mulw_s[31]}}, mulw_s};
            else if (op_q == OP_MUL)
                fin_res = prod_s[XLEN-1:0];
            else
                fin_res = prod_s[2*XLEN-1:XLEN];
        end else begin
            fin_res = op_w ? {{(XLEN-32){div_sel[31]}}, div_sel[31:0]} : div_sel;
        end
    end

    always_comb begin
        accept  = (state_q == IDLE) && start_i && !flush_i;
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = PREP;
            PREP:    state_d = special ? FIN : CALC;
            CALC:    if (cnt_q == 7'd1) state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush_i) state_d = IDLE;

        busy_o   = (state_q != IDLE);
        done_o   = (state_q == FIN) && !flush_i;
        result_o = done_o ? fin_res : result_q;
        rd_o     = done_o ? rd_q : rd_out_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            rd_q       <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            bm_q       <= '0;
            cnt_q      <= '0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            spec_q     <= 1'b0;
            spec_res_q <= '0;
            result_q   <= '0;
            rd_out_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q <= op_i;
                a_q  <= rs1_data_i;
                b_q  <= rs2_data_i;
                rd_q <= rd_i;
            end
            if (state_q == PREP) begin
                hi_q       <= '0;
                // W divides feed the dividend MSB-first, so park it in the upper word.
                lo_q       <= (op_div && op_w) ? {mag_a[31:0], 32'b0} : mag_a;
                bm_q       <= mag_b;
                neg_res_q  <= neg_a ^ neg_b;
                neg_rem_q  <= neg_a;
                spec_q     <= special;
                spec_res_q <= spec_res;
                cnt_q      <= op_w ? 7'(ITER32) : 7'(ITER64);
            end else if (state_q == CALC) begin
                hi_q  <= step_hi;
                lo_q  <= step_lo;
                cnt_q <= cnt_q - 7'd1;
            end
            if (done_o) begin
                result_q <= fin_res;
                rd_out_q <= rd_q;
            end
        end
    end

endmodule

// File: tb/tb_te_muldiv_unit.sv
// Self-checking bench for te_muldiv_unit: directed table, random ops vs. arithmetic model, flush/reset sequences.
module tb_te_muldiv_unit;

    logic        clk_i;
    logic        rst_ni;
    logic        start_i;
    logic        flush_i;
    logic [3:0]  op_i;
    logic [63:0] rs1_data_i;
    logic [63:0] rs2_data_i;
    logic [4:0]  rd_i;
    logic        busy_o;
    logic        done_o;
    logic [63:0] result_o;
    logic [4:0]  rd_o;

    int          n_vec = 0;
    int          n_err = 0;
    logic [63:0] last_res;
    logic [4:0]  last_rd;

    typedef struct {
        logic [3:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [4:0]  rd;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    vec_t tbl [0:17];

    te_muldiv_unit #(.XLEN(64)) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .start_i    (start_i),
        .flush_i    (flush_i),
        .op_i       (op_i),
        .rs1_data_i (rs1_data_i),
        .rs2_data_i (rs2_data_i),
        .rd_i       (rd_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .result_o   (result_o),
        .rd_o       (rd_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, got no summary, want completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] model_res(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        logic [127:0] ea, eb, p;
        longint       sa, sb;
        int           sa32, sb32;
        logic [31:0]  ua32, ub32, r32;
        sa = a; sb = b;
        ua32 = a[31:0]; ub32 = b[31:0];
        sa32 = ua32; sb32 = ub32;
        r32 = 32'h0;
        case (op)
            4'b0000: begin p = {64'h0, a} * {64'h0, b}; return p[63:0]; end
            4'b0001: begin ea = {{64{a[63]}}, a}; eb = {{64{b[63]}}, b}; p = ea * eb; return p[127:64]; end
            4'b0010: begin ea = {{64{a[63]}}, a}; eb = {64'h0, b}; p = ea * eb; return p[127:64]; end
            4'b0011: begin ea = {64'h0, a}; eb = {64'h0, b}; p = ea * eb; return p[127:64]; end
            4'b0100: begin
                if (b == 0) return '1;
                if (a == 64'h8000_0000_0000_0000 && b == '1) return a;
                return 64'(sa / sb);
            end
            4'b0101: return (b == 0) ? '1 : a / b;
            4'b0110: begin
                if (b == 0) return a;
                if (a == 64'h8000_0000_0000_0000 && b == '1) return 64'h0;
                return 64'(sa % sb);
            end
            4'b0111: return (b == 0) ? a : a % b;
            4'b1000: r32 = ua32 * ub32;
            4'b1100: begin
                if (ub32 == 0) r32 = '1;
                else if (ua32 == 32'h8000_0000 && ub32 == '1) r32 = ua32;
                else r32 = 32'(sa32 / sb32);
            end
            4'b1101: r32 = (ub32 == 0) ? '1 : ua32 / ub32;
            4'b1110: begin
                if (ub32 == 0) r32 = ua32;
                else if (ua32 == 32'h8000_0000 && ub32 == '1) r32 = 32'h0;
                else r32 = 32'(sa32 % sb32);
            end
            4'b1111: r32 = (ub32 == 0) ? ua32 : ua32 % ub32;
            default: return 64'h0;
        endcase
        return {{32{r32[31]}}, r32};
    endfunction

    function automatic int model_lat(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        if (op inside {4'b1001, 4'b1010, 4'b1011}) return 2;
        if (op[2]) begin
            if (op[3]) begin
                if (b[31:0] == 0) return 2;
                if (!op[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) return 2;
                return 34;
            end
            if (b == 0) return 2;
            if (!op[0] && a == 64'h8000_0000_0000_0000 && b == '1) return 2;
            return 66;
        end
        return op[3] ? 34 : 66;
    endfunction

    // Called at a negedge with the unit idle; returns at the negedge of the cycle after done_o.
    task automatic run_op(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                          input logic [4:0] rd, input logic [63:0] exp, input int lat, input string name);
        int   cyc;
        logic got;
        start_i = 1'b1; op_i = op; rs1_data_i = a; rs2_data_i = b; rd_i = rd;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        op_i = 4'($urandom);
        rs1_data_i = {$urandom, $urandom};
        rs2_data_i = {$urandom, $urandom};
        rd_i = 5'($urandom);
        cyc = 0; got = 1'b0;
        while (!got && cyc < 200) begin
            @(negedge clk_i);
            cyc++;
            got = done_o;
        end
        n_vec++;
        if (!got) begin
            n_err++;
            $display("FAIL %s timeout: got no done_o in %0d cycles, want done at %0d", name, cyc, lat);
        end else begin
            check({name, " result"}, result_o, exp);
            check({name, " rd"}, 64'(rd_o), 64'(rd));
            check({name, " latency"}, 64'(cyc), 64'(lat));
        end
        @(negedge clk_i);
        check({name, " done pulse"}, 64'(done_o), 64'h0);
        check({name, " busy after"}, 64'(busy_o), 64'h0);
        check({name, " result held"}, result_o, exp);
        last_res = exp;
        last_rd  = rd;
    endtask

    initial begin
        int   cyc;
        logic got;
        logic seen;

        rst_ni = 1'b0; start_i = 1'b0; flush_i = 1'b0; op_i = 4'h0;
        rs1_data_i = 64'h0; rs2_data_i = 64'h0; rd_i = 5'h0;
        last_res = 64'h0; last_rd = 5'h0;

        tbl[0]  = '{4'b0000, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd5, 64'hFFFF_FFFF_FFFF_FFEB, 66};
        tbl[1]  = '{4'b0011, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd6, 64'hFFFF_FFFF_FFFF_FFFE, 66};
        tbl[2]  = '{4'b0001, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd7, 64'h0, 66};
        tbl[3]  = '{4'b0100, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd8, 64'hFFFF_FFFF_FFFF_FFFD, 66};
        tbl[4]  = '{4'b0110, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd9, 64'hFFFF_FFFF_FFFF_FFFF, 66};
        tbl[5]  = '{4'b0101, 64'h1234, 64'h0, 5'd10, 64'hFFFF_FFFF_FFFF_FFFF, 2};
        tbl[6]  = '{4'b0111, 64'h1234, 64'h0, 5'd11, 64'h1234, 2};
        tbl[7]  = '{4'b0100, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd12, 64'h8000_0000_0000_0000, 2};
        tbl[8]  = '{4'b0110, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd13, 64'h0, 2};
        tbl[9]  = '{4'b1100, 64'h0000_0001_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd14, 64'hFFFF_FFFF_8000_0000, 2};
        tbl[10] = '{4'b1000, 64'h7FFF_FFFF, 64'd2, 5'd15, 64'hFFFF_FFFF_FFFF_FFFE, 34};
        tbl[11] = '{4'b1001, 64'd5, 64'd3, 5'd16, 64'h0, 2};
        tbl[12] = '{4'b1011, 64'd9, 64'd4, 5'd17, 64'h0, 2};
        tbl[13] = '{4'b1111, 64'hDEAD_BEEF_8000_0001, 64'h0, 5'd18, 64'hFFFF_FFFF_8000_0001, 2};
        tbl[14] = '{4'b1101, 64'hFFFF_FFFF, 64'd1, 5'd19, 64'hFFFF_FFFF_FFFF_FFFF, 34};
        tbl[15] = '{4'b1110, 64'hFFFF_FFFF_FFFF_FFF9, 64'h1234_5678_0000_0002, 5'd20, 64'hFFFF_FFFF_FFFF_FFFF, 34};
        tbl[16] = '{4'b0101, 64'd100, 64'd7, 5'd21, 64'hE, 66};
        tbl[17] = '{4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 66};

        repeat (3) @(negedge clk_i);
        n_vec++;
        check("reset busy", 64'(busy_o), 64'h0);
        check("reset done", 64'(done_o), 64'h0);
        check("reset result", result_o, 64'h0);
        check("reset rd", 64'(rd_o), 64'h0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        for (int i = 0; i < 18; i++)
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].rd, tbl[i].exp, tbl[i].lat, $sformatf("table[%0d]", i));

        for (int i = 0; i < 40; i++) begin
            logic [3:0]  op;
            logic [63:0] a, b;
            op = 4'($urandom_range(0, 15));
            a  = {$urandom, $urandom};
            b  = {$urandom, $urandom};
            case ($urandom_range(0, 9))
                0: b = 64'h0;
                1: b[31:0] = 32'h0;
                2: begin a = 64'h8000_0000_0000_0000; b = '1; end
                3: begin a[31:0] = 32'h8000_0000; b[31:0] = 32'hFFFF_FFFF; end
                4: b = 64'($urandom_range(1, 1000));
                default: ;
            endcase
            run_op(op, a, b, 5'($urandom), model_res(op, a, b), model_lat(op, a, b),
                   $sformatf("random[%0d] op=%b", i, op));
        end

        // Flush during CALC iteration 10 (cycle 11).
        run_op(4'b0000, 64'd3, 64'd5, 5'd11, 64'd15, 66, "pre-flush");
        start_i = 1'b1; op_i = 4'b0001; rs1_data_i = 64'h1234_5678_9ABC_DEF0; rs2_data_i = 64'h0FED_CBA9_8765_4321; rd_i = 5'd22;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        seen = 1'b0;
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk_i);
            if (done_o) seen = 1'b1;
            if (c == 11) flush_i = 1'b1;
        end
        @(negedge clk_i);
        n_vec++;
        check("flush busy", 64'(busy_o), 64'h0);
        check("flush done", 64'(done_o), 64'h0);
        check("flush result kept", result_o, last_res);
        check("flush rd kept", 64'(rd_o), 64'(last_rd));
        flush_i = 1'b0;
        repeat (70) begin
            @(negedge clk_i);
            if (done_o) seen = 1'b1;
        end
        check("flushed op no done", 64'(seen), 64'h0);
        run_op(4'b0101, 64'd1000, 64'd10, 5'd9, 64'd100, 66, "after flush");

        // start_i while busy is ignored and not queued.
        start_i = 1'b1; op_i = 4'b0101; rs1_data_i = 64'd1000; rs2_data_i = 64'd7; rd_i = 5'd3;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        cyc = 0; got = 1'b0;
        while (!got && cyc < 200) begin
            @(negedge clk_i);
            cyc++;
            got = done_o;
            if (cyc >= 3 && cyc <= 5) begin
                start_i = 1'b1; op_i = 4'b0000; rs1_data_i = 64'd5; rs2_data_i = 64'd5; rd_i = 5'd30;
            end else begin
                start_i = 1'b0;
            end
        end
        start_i = 1'b0;
        n_vec++;
        check("busy-start result", result_o, 64'd142);
        check("busy-start rd", 64'(rd_o), 64'd3);
        check("busy-start latency", 64'(cyc), 64'd66);
        repeat (3) @(negedge clk_i);
        check("busy-start not queued", 64'(busy_o), 64'h0);
        last_res = 64'd142; last_rd = 5'd3;

        // Flush arriving in the FIN cycle of a special-case op.
        start_i = 1'b1; op_i = 4'b0101; rs1_data_i = 64'd5; rs2_data_i = 64'd0; rd_i = 5'd7;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        @(posedge clk_i); #1;
        flush_i = 1'b1;
        @(negedge clk_i);
        n_vec++;
        check("fin-flush busy in FIN", 64'(busy_o), 64'h1);
        check("fin-flush done", 64'(done_o), 64'h0);
        @(posedge clk_i); #1;
        flush_i = 1'b0;
        @(negedge clk_i);
        check("fin-flush busy after", 64'(busy_o), 64'h0);
        check("fin-flush result kept", result_o, last_res);
        check("fin-flush rd kept", 64'(rd_o), 64'(last_rd));

        // Flush together with start drops the start.
        start_i = 1'b1; flush_i = 1'b1; op_i = 4'b0000; rs1_data_i = 64'd2; rs2_data_i = 64'd2; rd_i = 5'd1;
        @(negedge clk_i);
        n_vec++;
        check("start+flush busy", 64'(busy_o), 64'h0);
        start_i = 1'b0; flush_i = 1'b0;
        @(negedge clk_i);
        check("start+flush still idle", 64'(busy_o), 64'h0);

        // Asynchronous reset in the middle of an op.
        start_i = 1'b1; op_i = 4'b0100; rs1_data_i = 64'd1000; rs2_data_i = 64'd3; rd_i = 5'd25;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        repeat (20) @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        n_vec++;
        check("midop reset busy", 64'(busy_o), 64'h0);
        check("midop reset done", 64'(done_o), 64'h0);
        check("midop reset result", result_o, 64'h0);
        check("midop reset rd", 64'(rd_o), 64'h0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        run_op(4'b0110, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd4, 64'hFFFF_FFFF_FFFF_FFFF, 66, "after reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
